// File: rtl/down_counter_timer.sv
// Programmable down-counter with registered borrow pulse, one-shot or auto-reload operation.
// A borrow is flagged when decrementing from zero; q itself never wraps.
module down_counter_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic             decr_i,
  input  logic             auto_reload_i,
  output logic [WIDTH-1:0] q_o,
  output logic             b_o,
  output logic             zero_o,
  output logic             running_o
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic             b_q, b_d;
  logic [0:0]       state_q, state_d;
  logic [WIDTH:0]   dec_val;
  logic             underflow;

  // The extra top bit of the decrement is the borrow; only the low bits ever reach q.
  assign dec_val   = {1'b0, q_q} - {{WIDTH{1'b0}}, 1'b1};
  assign underflow = dec_val[WIDTH];

  always_comb begin
    q_d     = q_q;
    rld_d   = rld_q;
    b_d     = 1'b0;
    state_d = state_q;
    if (clear_i) begin
      q_d     = '0;
      state_d = StIdle;
    end else if (load_i) begin
      q_d     = d_i;
      rld_d   = d_i;
      state_d = StRun;
    end else if (state_q == StRun && decr_i) begin
      if (underflow) begin
        b_d = 1'b1;
        if (auto_reload_i) begin
          q_d = rld_q;
        end else begin
          state_d = StIdle;
        end
      end else begin
        q_d = dec_val[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q     <= '0;
      rld_q   <= '0;
      b_q     <= 1'b0;
      state_q <= StIdle;
    end else begin
      q_q     <= q_d;
      rld_q   <= rld_d;
      b_q     <= b_d;
      state_q <= state_d;
    end
  end

  assign q_o       = q_q;
  assign b_o       = b_q;
  assign zero_o    = (q_q == '0);
  assign running_o = (state_q == StRun);

endmodule

// File: tb/tb_down_counter_timer.sv
// Bench for down_counter_timer: directed scenarios plus randomized run against a rule-level model.
// Two instances are cascaded (stage0 borrow drives stage1 decrement).
module tb_down_counter_timer;

  localparam int W = 4;

  logic         clk, rst;
  logic [W-1:0] d0, d1;
  logic         load0, clear0, decr0, auto0;
  logic         load1, clear1, auto1;
  logic [W-1:0] q0, q1;
  logic         b0, b1, z0, z1, r0, r1;

  int checks = 0;
  int errors = 0;

  // Model state per stage, updated from the behavioural rules at each clock edge.
  logic [W-1:0] m_q   [2];
  logic [W-1:0] m_rld [2];
  logic         m_b   [2];
  logic         m_run [2];

  down_counter_timer #(.WIDTH(W)) u0 (
    .clk_i(clk), .rst_i(rst), .d_i(d0), .load_i(load0), .clear_i(clear0),
    .decr_i(decr0), .auto_reload_i(auto0), .q_o(q0), .b_o(b0), .zero_o(z0), .running_o(r0)
  );

  down_counter_timer #(.WIDTH(W)) u1 (
    .clk_i(clk), .rst_i(rst), .d_i(d1), .load_i(load1), .clear_i(clear1),
    .decr_i(b0), .auto_reload_i(auto1), .q_o(q1), .b_o(b1), .zero_o(z1), .running_o(r1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_q[s] = '0; m_rld[s] = '0; m_b[s] = 1'b0; m_run[s] = 1'b0;
    end
  endtask

  task automatic apply(input int s, input logic clr, input logic ld, input logic [W-1:0] dv,
                       input logic dec, input logic au);
    m_b[s] = 1'b0;
    if (clr) begin
      m_q[s] = '0; m_run[s] = 1'b0;
    end else if (ld) begin
      m_q[s] = dv; m_rld[s] = dv; m_run[s] = 1'b1;
    end else if (m_run[s] && dec) begin
      if (m_q[s] == 0) begin
        m_b[s] = 1'b1;
        if (au) m_q[s] = m_rld[s];
        else m_run[s] = 1'b0;
      end else begin
        m_q[s] = m_q[s] - 1'b1;
      end
    end
  endtask

  task automatic step();
    logic b0_prev;
    @(posedge clk);
    b0_prev = m_b[0];
    apply(0, clear0, load0, d0, decr0, auto0);
    apply(1, clear1, load1, d1, b0_prev, auto1);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks += 4;
    if (q0 !== 4'd0) begin errors++; $display("FAIL reset_q got %0d want 0", q0); end
    if (b0 !== 1'b0) begin errors++; $display("FAIL reset_b got %0b want 0", b0); end
    if (r0 !== 1'b0) begin errors++; $display("FAIL reset_running got %0b want 0", r0); end
    if (z0 !== 1'b1) begin errors++; $display("FAIL reset_zero got %0b want 1", z0); end
    @(negedge clk);
    rst = 1'b0;
    load0 = 1'b1; d0 = 4'd5; step();
    load0 = 1'b0; decr0 = 1'b1; step(); step();
    checks++;
    if (q0 !== 4'd3) begin errors++; $display("FAIL midcount_q got %0d want 3", q0); end
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks += 4;
    if (q0 !== 4'd0) begin errors++; $display("FAIL async_rst_q got %0d want 0", q0); end
    if (b0 !== 1'b0) begin errors++; $display("FAIL async_rst_b got %0b want 0", b0); end
    if (r0 !== 1'b0) begin errors++; $display("FAIL async_rst_running got %0b want 0", r0); end
    if (z0 !== 1'b1) begin errors++; $display("FAIL async_rst_zero got %0b want 1", z0); end
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks += 2;
      if (q0 !== 4'd0) begin errors++; $display("FAIL post_rst_q got %0d want 0", q0); end
      if (r0 !== 1'b0) begin errors++; $display("FAIL post_rst_running got %0b want 0", r0); end
    end
    decr0 = 1'b0;
  endtask

  task automatic test_one_shot();
    logic [W-1:0] eq [6];
    logic         eb [6];
    logic         er [6];
    eq = '{4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
    eb = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    er = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    load0 = 1'b1; d0 = 4'd3; auto0 = 1'b0; decr0 = 1'b1;
    step();
    checks += 2;
    if (q0 !== 4'd3) begin errors++; $display("FAIL oneshot_load_q got %0d want 3", q0); end
    if (r0 !== 1'b1) begin errors++; $display("FAIL oneshot_load_run got %0b want 1", r0); end
    load0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks += 3;
      if (q0 !== eq[i]) begin errors++; $display("FAIL oneshot_q[%0d] got %0d want %0d", i, q0, eq[i]); end
      if (b0 !== eb[i]) begin errors++; $display("FAIL oneshot_b[%0d] got %0b want %0b", i, b0, eb[i]); end
      if (r0 !== er[i]) begin errors++; $display("FAIL oneshot_run[%0d] got %0b want %0b", i, r0, er[i]); end
    end
    decr0 = 1'b0;
  endtask

  task automatic test_auto_reload();
    logic [W-1:0] eq [9];
    eq = '{4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2};
    load0 = 1'b1; d0 = 4'd2; auto0 = 1'b1; decr0 = 1'b0;
    step();
    load0 = 1'b0; decr0 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      checks += 3;
      if (q0 !== eq[i]) begin errors++; $display("FAIL autoreload_q[%0d] got %0d want %0d", i, q0, eq[i]); end
      if (b0 !== (i % 3 == 2)) begin
        errors++; $display("FAIL autoreload_b[%0d] got %0b want %0b", i, b0, (i % 3 == 2));
      end
      if (r0 !== 1'b1) begin errors++; $display("FAIL autoreload_run[%0d] got %0b want 1", i, r0); end
    end
    decr0 = 1'b0;
  endtask

  task automatic test_priority();
    load0 = 1'b1; d0 = 4'd7; decr0 = 1'b0;
    step();
    checks++;
    if (q0 !== 4'd7) begin errors++; $display("FAIL prio_setup_q got %0d want 7", q0); end
    clear0 = 1'b1; load0 = 1'b1; d0 = 4'd9; decr0 = 1'b1;
    step();
    checks += 3;
    if (q0 !== 4'd0) begin errors++; $display("FAIL prio_clear_q got %0d want 0", q0); end
    if (r0 !== 1'b0) begin errors++; $display("FAIL prio_clear_run got %0b want 0", r0); end
    if (z0 !== 1'b1) begin errors++; $display("FAIL prio_clear_zero got %0b want 1", z0); end
    clear0 = 1'b0;
    step();
    checks += 2;
    if (q0 !== 4'd9) begin errors++; $display("FAIL prio_load_q got %0d want 9", q0); end
    if (r0 !== 1'b1) begin errors++; $display("FAIL prio_load_run got %0b want 1", r0); end
    load0 = 1'b0;
    step();
    checks++;
    if (q0 !== 4'd8) begin errors++; $display("FAIL prio_decr_q got %0d want 8", q0); end
    decr0 = 1'b0;
  endtask

  task automatic test_zero_load();
    load0 = 1'b1; d0 = 4'd0; auto0 = 1'b1; decr0 = 1'b1;
    step();
    checks += 3;
    if (q0 !== 4'd0) begin errors++; $display("FAIL zeroload_q got %0d want 0", q0); end
    if (r0 !== 1'b1) begin errors++; $display("FAIL zeroload_run got %0b want 1", r0); end
    if (b0 !== 1'b0) begin errors++; $display("FAIL zeroload_b got %0b want 0", b0); end
    load0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks += 3;
      if (q0 !== 4'd0) begin errors++; $display("FAIL zeroload_q[%0d] got %0d want 0", i, q0); end
      if (b0 !== 1'b1) begin errors++; $display("FAIL zeroload_b[%0d] got %0b want 1", i, b0); end
      if (r0 !== 1'b1) begin errors++; $display("FAIL zeroload_run[%0d] got %0b want 1", i, r0); end
    end
    decr0 = 1'b0;
  endtask

  task automatic test_cascade();
    clear0 = 1'b1; clear1 = 1'b1; decr0 = 1'b0;
    step();
    clear0 = 1'b0; clear1 = 1'b0;
    load0 = 1'b1; load1 = 1'b1; d0 = 4'd1; d1 = 4'd1; auto0 = 1'b1; auto1 = 1'b1;
    step();
    load0 = 1'b0; load1 = 1'b0; decr0 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      checks += 3;
      if (b0 !== (i % 2 == 0)) begin
        errors++; $display("FAIL cascade_b0[%0d] got %0b want %0b", i, b0, (i % 2 == 0));
      end
      if (b1 !== (i == 5 || i == 9)) begin
        errors++; $display("FAIL cascade_b1[%0d] got %0b want %0b", i, b1, (i == 5 || i == 9));
      end
      if (q1 !== m_q[1]) begin errors++; $display("FAIL cascade_q1[%0d] got %0d want %0d", i, q1, m_q[1]); end
    end
    decr0 = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] aq [2];
    logic         ab [2];
    logic         ar [2];
    logic         az [2];
    for (int i = 0; i < 400; i++) begin
      clear0 = ($urandom_range(0, 19) == 0);
      load0  = ($urandom_range(0, 9) == 0);
      d0     = 4'($urandom_range(0, 15));
      decr0  = ($urandom_range(0, 3) != 0);
      auto0  = 1'($urandom_range(0, 1));
      clear1 = ($urandom_range(0, 39) == 0);
      load1  = ($urandom_range(0, 19) == 0);
      d1     = 4'($urandom_range(0, 3));
      auto1  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b1;
        #1 model_reset();
        #1 rst = 1'b0;
      end
      step();
      aq[0] = q0; ab[0] = b0; ar[0] = r0; az[0] = z0;
      aq[1] = q1; ab[1] = b1; ar[1] = r1; az[1] = z1;
      for (int s = 0; s < 2; s++) begin
        checks += 4;
        if (aq[s] !== m_q[s]) begin
          errors++; $display("FAIL rand_q s%0d cyc %0d got %0d want %0d", s, i, aq[s], m_q[s]);
        end
        if (ab[s] !== m_b[s]) begin
          errors++; $display("FAIL rand_b s%0d cyc %0d got %0b want %0b", s, i, ab[s], m_b[s]);
        end
        if (ar[s] !== m_run[s]) begin
          errors++; $display("FAIL rand_run s%0d cyc %0d got %0b want %0b", s, i, ar[s], m_run[s]);
        end
        if (az[s] !== (m_q[s] == 0)) begin
          errors++; $display("FAIL rand_zero s%0d cyc %0d got %0b want %0b", s, i, az[s], (m_q[s] == 0));
        end
      end
    end
    clear0 = 1'b0; load0 = 1'b0; decr0 = 1'b0; clear1 = 1'b0; load1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    d0 = '0; load0 = 1'b0; clear0 = 1'b0; decr0 = 1'b0; auto0 = 1'b0;
    d1 = '0; load1 = 1'b0; clear1 = 1'b0; auto1 = 1'b0;
    model_reset();
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_priority();
    test_zero_load();
    test_cascade();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Programmable down-counter with borrow-out; the decrementing counterpart to the team's 4-bit up-counter (load/clear/incr/carry).
- Used as an interval timer or event down-counter.
- Borrow pulse cascades into a downstream up-counter's incr, or into another down_counter_timer's decr.
- Supports one-shot mode (stop at zero) and auto-reload mode (periodic borrow).

Parameters:
- WIDTH, 4, counter and reload-register width in bits (WIDTH >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- d  input  WIDTH  load value.
- load  input  1  synchronous load of d into q and the reload register.
- clear  input  1  synchronous clear of q; returns to IDLE.
- decr  input  1  decrement enable, one count per cycle while RUN.
- auto_reload  input  1  1: reload from the reload register on underflow; 0: stop at zero.
- q  output  WIDTH  current count, registered.
- b  output  1  borrow/underflow pulse, registered, one cycle.
- zero  output  1  combinational, q == 0.
- running  output  1  registered, high in state RUN.

Behaviour:
- Internal state:
  - rld[WIDTH-1:0] reload register.
  - 2-state FSM: IDLE, RUN.
- Reset (rst=1, asynchronous, any time including mid-count):
  - q=0, rld=0, b=0, state=IDLE, running=0, zero=1.
  - Takes effect without a clock edge.
  - First active edge is the first clk rise after rst falls.
- Per-edge priority: clear > load > decr.
- clear=1:
  - q<=0, b<=0, state<=IDLE.
  - rld unchanged.
  - load and decr ignored that cycle.
- load=1 (clear=0):
  - q<=d, rld<=d, b<=0, state<=RUN.
  - decr ignored that cycle.
  - Valid from either state.
  - d=0 is legal: enters RUN with q=0.
- IDLE, no clear/load:
  - q holds, b<=0.
  - decr has no effect.
- RUN, decr=0: q holds, b<=0.
- RUN, decr=1, q!=0: q<=q-1, b<=0.
- RUN, decr=1, q==0 (underflow), b<=1 in both modes:
  - auto_reload=1: q<=rld, state stays RUN.
  - auto_reload=0: q stays 0, state<=IDLE.
  - auto_reload is sampled only on the underflow edge.
- Latency:
  - q updates on the same edge decr/load/clear is sampled.
  - b is asserted during the cycle after the underflow edge, for exactly one cycle unless underflow repeats.
- Period (auto-reload, decr held high): one b pulse every rld+1 cycles.
  - rld=0 gives b high continuously.
- Cascade rule: b of stage n drives decr of stage n+1.
  - The lag between stages is one cycle.
- Borrow width: computed as bit WIDTH of ({1'b0,q} - 1).
  - Must never reach q; q never wraps to all-ones.
- zero derives from q only: no extra register, no dependence on state.

Test Plan:
- Reset mid-count: WIDTH=4, load d=5, decr 2 cycles (q=3), pulse rst asynchronously between edges -> q=0, b=0, running=0, zero=1 immediately; subsequent decr ignored.
- One-shot: load d=3, auto_reload=0, decr held high -> q=2,1,0 on successive edges; next edge b=1 for one cycle, q=0, running=0; further decr leaves q=0, b=0.
- Auto-reload period: load d=2, auto_reload=1, decr high for 9 cycles -> q sequence 1,0,2,1,0,2,1,0,2; b high in exactly the cycles where q just became 2 (every 3 cycles).
- Priority: q=7 in RUN, assert clear, load (d=9) and decr together -> q=0, IDLE, rld unchanged; next cycle load d=9 with decr=1 -> q=9, RUN, no decrement that cycle.
- Zero-load edge: load d=0, auto_reload=1, decr high 3 cycles -> q stays 0, b=1 on every cycle after each edge, running stays 1.
- Cascade: two instances, stage0 b -> stage1 decr, both loaded d=1, auto_reload=1, decr0 high -> stage1 underflows once every 4 stage0 cycles; its b appears one cycle after stage0's second borrow.
